// File: rtl/smpl_trig_capture.sv
// Pre-triggered multi-channel sample capture: decimate, ring-buffer, trigger search,
// then stream the finished record oldest-first over a valid/ready output.
module smpl_trig_capture #(
    parameter int SN    = 12,
    parameter int CH    = 2,
    parameter int DEPTH = 256,
    parameter int PRE   = 64,
    parameter int DW    = 8,
    parameter int TOW   = 16,
    localparam int CW   = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic              clkSmpl,
    input  logic              n_reset,
    input  logic              arm,
    input  logic              abort,
    input  logic [CW-1:0]     trig_ch,
    input  logic [SN-1:0]     trig_level,
    input  logic              trig_rise,
    input  logic              trig_auto,
    input  logic [TOW-1:0]    auto_to,
    input  logic [DW-1:0]     decim,
    input  logic              smpl_valid,
    output logic              smpl_req,
    input  logic [CH*SN-1:0]  smpl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH*SN-1:0]  out_data,
    output logic              out_last,
    output logic              busy,
    output logic              triggered,
    output logic              forced,
    output logic              done,
    output logic [2:0]        dbg_state
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_FILL = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_POST = 3'd3;
    localparam logic [2:0] ST_DUMP = 3'd4;
    localparam logic [AW:0]     FILL_LAST = (AW+1)'(PRE - 1);
    localparam logic [AW:0]     POST_LAST = (AW+1)'(DEPTH - PRE - 2);
    localparam logic [AW:0]     DUMP_LAST = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0]     DUMP_ALL  = (AW+1)'(DEPTH);
    localparam logic [AW:0]     CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0]   PTR_ONE   = AW'(1);
    localparam logic [AW-1:0]   PRE_OFS   = AW'(PRE);
    localparam logic [DW-1:0]   DEC_ONE   = DW'(1);
    localparam logic [TOW-1:0]  TO_ONE    = TOW'(1);

    // Handshake: a word transfers on every clkSmpl edge where out_valid && out_ready;
    // out_data/out_last stay frozen while out_valid is high and out_ready is low.

    logic [2:0]        state_q, state_d;
    logic [CW-1:0]     trig_ch_q, trig_ch_d;
    logic [SN-1:0]     level_q, level_d;
    logic              rise_q, rise_d;
    logic              auto_q, auto_d;
    logic [TOW-1:0]    auto_to_q, auto_to_d;
    logic [DW-1:0]     decim_q, decim_d;
    logic [DW-1:0]     dcnt_q, dcnt_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     trig_pos_q, trig_pos_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic [TOW-1:0]    wait_cnt_q, wait_cnt_d;
    logic [SN-1:0]     prev_q, prev_d;
    logic              prev_valid_q, prev_valid_d;
    logic              triggered_q, triggered_d;
    logic              forced_q, forced_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [CH*SN-1:0]  out_data_q, out_data_d;
    logic              done_q, done_d;

    logic [CH*SN-1:0]  mem_q [DEPTH];
    logic              mem_we;

    logic              capturing, accept, keep, hit, auto_hit, load, last_hs;
    logic [SN-1:0]     cur_trig;

    always_comb begin
        capturing = (state_q == ST_FILL) || (state_q == ST_WAIT) || (state_q == ST_POST);
        accept    = smpl_valid && capturing;
        keep      = accept && (dcnt_q == '0);
        auto_hit  = auto_q && (wait_cnt_q == auto_to_q);
        load      = (state_q == ST_DUMP) && (cnt_q != DUMP_ALL) && (!out_valid_q || out_ready);
        last_hs   = (state_q == ST_DUMP) && out_valid_q && out_ready && out_last_q;
    end

    always_comb begin
        cur_trig = '0;
        for (int c = 0; c < CH; c++) begin
            if (trig_ch_q == CW'(c)) cur_trig = smpl[c*SN +: SN];
        end
        hit = prev_valid_q && (rise_q ? (prev_q < level_q && cur_trig >= level_q)
                                      : (prev_q > level_q && cur_trig <= level_q));
    end

    always_comb begin
        state_d      = state_q;
        trig_ch_d    = trig_ch_q;
        level_d      = level_q;
        rise_d       = rise_q;
        auto_d       = auto_q;
        auto_to_d    = auto_to_q;
        decim_d      = decim_q;
        dcnt_d       = dcnt_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        trig_pos_d   = trig_pos_q;
        cnt_d        = cnt_q;
        wait_cnt_d   = wait_cnt_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        triggered_d  = triggered_q;
        forced_d     = forced_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_data_d   = out_data_q;
        done_d       = 1'b0;
        mem_we       = 1'b0;
        if (abort) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            if (accept) dcnt_d = (dcnt_q == decim_q) ? '0 : dcnt_q + DEC_ONE;
            if (keep) begin
                mem_we       = 1'b1;
                wr_ptr_d     = wr_ptr_q + PTR_ONE;
                prev_d       = cur_trig;
                prev_valid_d = 1'b1;
            end
            case (state_q)
                ST_IDLE: if (arm) begin
                    state_d      = ST_FILL;
                    trig_ch_d    = trig_ch;
                    level_d      = trig_level;
                    rise_d       = trig_rise;
                    auto_d       = trig_auto;
                    auto_to_d    = auto_to;
                    decim_d      = decim;
                    dcnt_d       = '0;
                    wr_ptr_d     = '0;
                    cnt_d        = '0;
                    wait_cnt_d   = '0;
                    prev_valid_d = 1'b0;
                    triggered_d  = 1'b0;
                    forced_d     = 1'b0;
                end
                ST_FILL: if (keep) begin
                    if (cnt_q == FILL_LAST) begin
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_WAIT: if (keep) begin
                    // A real crossing takes precedence over the timeout on the same sample.
                    if (hit || auto_hit) begin
                        state_d     = ST_POST;
                        triggered_d = 1'b1;
                        forced_d    = !hit;
                        trig_pos_d  = wr_ptr_q;
                    end else begin
                        wait_cnt_d = wait_cnt_q + TO_ONE;
                    end
                end
                ST_POST: if (keep) begin
                    if (cnt_q == POST_LAST) begin
                        state_d  = ST_DUMP;
                        cnt_d    = '0;
                        rd_ptr_d = trig_pos_q - PRE_OFS;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_DUMP: begin
                    // out_data_q is the RAM's registered read port, refilled whenever it drains.
                    if (load) begin
                        out_data_d  = mem_q[rd_ptr_q];
                        out_valid_d = 1'b1;
                        out_last_d  = (cnt_q == DUMP_LAST);
                        rd_ptr_d    = rd_ptr_q + PTR_ONE;
                        cnt_d       = cnt_q + CNT_ONE;
                    end else if (out_ready) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end
                    if (last_hs) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clkSmpl or negedge n_reset) begin
        if (!n_reset) begin
            state_q      <= ST_IDLE;
            trig_ch_q    <= '0;
            level_q      <= '0;
            rise_q       <= 1'b0;
            auto_q       <= 1'b0;
            auto_to_q    <= '0;
            decim_q      <= '0;
            dcnt_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            trig_pos_q   <= '0;
            cnt_q        <= '0;
            wait_cnt_q   <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            triggered_q  <= 1'b0;
            forced_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            trig_ch_q    <= trig_ch_d;
            level_q      <= level_d;
            rise_q       <= rise_d;
            auto_q       <= auto_d;
            auto_to_q    <= auto_to_d;
            decim_q      <= decim_d;
            dcnt_q       <= dcnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            trig_pos_q   <= trig_pos_d;
            cnt_q        <= cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            triggered_q  <= triggered_d;
            forced_q     <= forced_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_data_q   <= out_data_d;
            done_q       <= done_d;
        end
    end

    always_ff @(posedge clkSmpl) begin
        if (mem_we) mem_q[wr_ptr_q] <= smpl;
    end

    assign smpl_req  = capturing;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != ST_IDLE);
    assign triggered = triggered_q;
    assign forced    = forced_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_smpl_trig_capture.sv
// Bench for smpl_trig_capture: directed scenarios plus randomized captures, each record
// predicted from the kept-sample list by index arithmetic and compared word by word.
module tb_smpl_trig_capture;
    localparam int SN = 12, CH = 2, DEPTH = 16, PRE = 4, DW = 8, TOW = 16;
    localparam int W = CH * SN;

    logic           clkSmpl = 1'b0;
    logic           n_reset = 1'b0;
    logic           arm = 1'b0, abort = 1'b0;
    logic [0:0]     trig_ch = '0;
    logic [SN-1:0]  trig_level = '0;
    logic           trig_rise = 1'b0, trig_auto = 1'b0;
    logic [TOW-1:0] auto_to = '0;
    logic [DW-1:0]  decim = '0;
    logic           smpl_valid = 1'b0;
    logic [W-1:0]   smpl = '0;
    logic           out_ready = 1'b0;
    logic           smpl_req, out_valid, out_last, busy, triggered, forced, done;
    logic [W-1:0]   out_data;
    logic [2:0]     dbg_state;

    smpl_trig_capture #(.SN(SN), .CH(CH), .DEPTH(DEPTH), .PRE(PRE), .DW(DW), .TOW(TOW)) dut (
        .clkSmpl(clkSmpl), .n_reset(n_reset), .arm(arm), .abort(abort), .trig_ch(trig_ch),
        .trig_level(trig_level), .trig_rise(trig_rise), .trig_auto(trig_auto),
        .auto_to(auto_to), .decim(decim), .smpl_valid(smpl_valid), .smpl_req(smpl_req),
        .smpl(smpl), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .triggered(triggered), .forced(forced),
        .done(done), .dbg_state(dbg_state)
    );

    always #5 clkSmpl = ~clkSmpl;

    int n_cmp = 0, n_mis = 0;
    logic [W-1:0] kept_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got [DEPTH];
    int  m_acc, m_trig, gen_idx;
    bit  m_active = 0, m_forced = 0;
    int  c_ch, c_lvl, c_to, c_decim;
    bit  c_rise, c_auto;
    bit  ab;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clkSmpl);
    endtask

    function automatic logic [SN-1:0] lane(input logic [W-1:0] w, input int ch);
        return w[ch*SN +: SN];
    endfunction

    function automatic logic [30:0] outs_vec();
        return {out_valid, out_last, busy, triggered, forced, done, smpl_req, out_data};
    endfunction

    function automatic logic [W-1:0] gen(input int mode, input int idx);
        logic [SN-1:0] a, b;
        a = SN'($urandom);
        b = SN'($urandom);
        case (mode)
            0: a = SN'(idx * 10);
            1: begin a = SN'(idx); b = SN'(idx); end
            2: begin a = SN'(50); b = SN'(50); end
            4: b = (idx < 8) ? SN'(200) : (idx < 11) ? SN'(250) : SN'(150);
            default: ;
        endcase
        return {b, a};
    endfunction

    // Reference: record = kept[t-PRE .. t+DEPTH-PRE-1], t = first qualifying Wait sample.
    task automatic model_keep(input logic [W-1:0] s);
        int k;
        logic [SN-1:0] cur, prv;
        kept_q.push_back(s);
        k = kept_q.size() - 1;
        if (m_trig < 0) begin
            if (k >= PRE) begin
                cur = lane(s, c_ch);
                prv = lane(kept_q[k-1], c_ch);
                if (c_rise ? (prv < SN'(c_lvl) && cur >= SN'(c_lvl))
                           : (prv > SN'(c_lvl) && cur <= SN'(c_lvl))) begin
                    m_trig = k;
                end else if (c_auto && (k - PRE) == c_to) begin
                    m_trig = k;
                    m_forced = 1;
                end
            end
        end else if (k == m_trig + DEPTH - PRE - 1) begin
            m_active = 0;
            for (int i = m_trig - PRE; i <= k; i++) exp_q.push_back(kept_q[i]);
        end
    endtask

    task automatic model_accept(input logic [W-1:0] s);
        if (m_acc % (c_decim + 1) == 0) model_keep(s);
        m_acc++;
    endtask

    task automatic scramble();
        trig_ch    = 1'($urandom);
        trig_level = SN'($urandom);
        trig_rise  = 1'($urandom);
        trig_auto  = 1'($urandom);
        auto_to    = TOW'($urandom_range(0, 3));
        decim      = DW'($urandom_range(0, 7));
    endtask

    task automatic do_arm(input int ch, input int lvl, input bit rise, input bit au,
                          input int to, input int dec);
        trig_ch = 1'(ch); trig_level = SN'(lvl); trig_rise = rise;
        trig_auto = au; auto_to = TOW'(to); decim = DW'(dec);
        arm = 1;
        c_ch = ch; c_lvl = lvl; c_rise = rise; c_auto = au; c_to = to; c_decim = dec;
        kept_q.delete(); exp_q.delete();
        m_acc = 0; m_trig = -1; m_forced = 0; gen_idx = 0;
        tick();
        arm = 0;
        scramble();
        m_active = 1;
    endtask

    task automatic capture(input int mode, input int vpct, input int abort_post,
                           input bit arm_in_wait, output bit aborted);
        bit rearmed = 0;
        aborted = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            chk("smpl_req", smpl_req, m_active);
            chk("triggered", triggered, m_trig >= 0);
            chk("forced", forced, m_forced);
            arm = 0;
            if (!m_active) begin
                smpl_valid = 0;
                return;
            end
            chk("busy_capture", busy, 1);
            if (abort_post >= 0 && m_trig >= 0 && (kept_q.size() - 1 - m_trig) >= abort_post) begin
                smpl_valid = 0;
                abort = 1;
                tick();
                abort = 0;
                chk("abort_post_busy", busy, 0);
                chk("abort_post_req", smpl_req, 0);
                chk("abort_post_done", done, 0);
                m_active = 0;
                aborted = 1;
                return;
            end
            if (arm_in_wait && !rearmed && m_trig < 0 && kept_q.size() > PRE) begin
                arm = 1;
                rearmed = 1;
            end
            smpl_valid = ($urandom_range(0, 99) < vpct);
            smpl = gen(mode, gen_idx);
            if (smpl_valid) begin
                gen_idx++;
                model_accept(smpl);
            end
            tick();
        end
        n_cmp++;
        n_mis++;
        $error("FAIL capture_timeout: observed no completed record, required one within 3000 cycles");
        smpl_valid = 0;
        abort = 1;
        tick();
        abort = 0;
        m_active = 0;
        aborted = 1;
    endtask

    // kill_kind: 0 none, 1 abort after kill_at handshakes, 2 async reset after kill_at.
    task automatic dump(input int rmode, input int kill_at, input int kill_kind);
        int c = 0, n = 0;
        bit stalled = 0, seen = 0;
        logic [W-1:0] held = '0, e;
        while (n < DEPTH) begin
            c++;
            if (c > 400) begin
                n_cmp++;
                n_mis++;
                $error("FAIL dump_timeout: observed %0d samples, required %0d", n, DEPTH);
                abort = 1; tick(); abort = 0; out_ready = 0;
                exp_q.delete();
                return;
            end
            if (out_valid) seen = 1;
            if (c == 2) chk("valid_latency", seen, 1);
            if (stalled) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, held);
            end
            chk("done_early", done, 0);
            chk("busy_dump", busy, 1);
            if (kill_kind != 0 && n == kill_at) begin
                out_ready = 0;
                if (kill_kind == 1) begin
                    abort = 1;
                    tick();
                    abort = 0;
                    chk("abort_dump_busy", busy, 0);
                    chk("abort_dump_valid", out_valid, 0);
                    chk("abort_dump_req", smpl_req, 0);
                    repeat (3) begin
                        tick();
                        chk("abort_dump_no_done", done, 0);
                    end
                end else begin
                    #2 n_reset = 0;
                    #1 chk("reset_in_dump", outs_vec(), 0);
                    tick();
                    chk("reset_held", outs_vec(), 0);
                    n_reset = 1;
                    tick();
                    chk("reset_released", outs_vec(), 0);
                end
                exp_q.delete();
                return;
            end
            case (rmode)
                0: out_ready = 1;
                1: out_ready = (c % 2 == 1);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_mis++;
                    $error("FAIL extra_output: observed %0h with no sample expected", out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e);
                end
                chk("out_last", out_last, n == DEPTH - 1);
                got[n] = out_data;
                n++;
                stalled = 0;
            end else begin
                stalled = out_valid;
                held = out_data;
            end
            tick();
        end
        out_ready = 0;
        chk("done_pulse", done, 1);
        chk("idle_valid", out_valid, 0);
        chk("idle_busy", busy, 0);
        tick();
        chk("done_width", done, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_reset = 0;
        repeat (3) tick();
        chk("reset_outputs", outs_vec(), 0);
        n_reset = 1;
        tick();
        chk("idle_after_reset", outs_vec(), 0);

        arm = 1; abort = 1;
        tick();
        arm = 0; abort = 0;
        chk("arm_abort_busy", busy, 0);
        chk("arm_abort_req", smpl_req, 0);

        // Rising ramp on ch0, trigger at 100.
        do_arm(0, 100, 1, 0, 0, 0);
        capture(0, 100, -1, 0, ab);
        dump(0, -1, 0);
        chk("ramp_first", lane(got[0], 0), 60);
        chk("ramp_trig", lane(got[PRE], 0), 100);
        chk("ramp_last", lane(got[DEPTH-1], 0), 210);
        chk("ramp_triggered", triggered, 1);
        chk("ramp_forced", forced, 0);

        // Decimation by 3 with valid gaps; arm pulse during Wait must be ignored.
        do_arm(0, 30, 1, 0, 0, 2);
        capture(1, 60, -1, 1, ab);
        dump(1, -1, 0);
        for (int i = 1; i < DEPTH; i++)
            chk("decim_step", lane(got[i], 0) - lane(got[i-1], 0), 3);

        // Auto timeout on flat input.
        do_arm(0, 100, 1, 1, 5, 0);
        capture(2, 80, -1, 0, ab);
        chk("auto_forced", forced, 1);
        dump(1, -1, 0);
        chk("auto_first", got[0], {SN'(50), SN'(50)});
        chk("auto_last", got[DEPTH-1], {SN'(50), SN'(50)});

        // Abort mid-Post, then a full record.
        do_arm(0, 2048, 1, 0, 0, 1);
        capture(3, 100, 3, 0, ab);
        do_arm(0, 2048, 1, 0, 0, 1);
        capture(3, 90, -1, 0, ab);
        dump(2, -1, 0);

        // Abort mid-Dump, then a full record.
        do_arm(1, 1000, 0, 0, 0, 0);
        capture(3, 100, -1, 0, ab);
        dump(0, 5, 1);
        do_arm(1, 1000, 0, 0, 0, 0);
        capture(3, 100, -1, 0, ab);
        dump(1, -1, 0);

        // Asynchronous reset during Dump.
        do_arm(0, 500, 1, 0, 0, 0);
        capture(3, 100, -1, 0, ab);
        dump(2, 7, 2);

        // Falling edge on ch1 starting exactly at the level.
        do_arm(1, 200, 0, 0, 0, 0);
        capture(4, 100, -1, 0, ab);
        dump(0, -1, 0);
        chk("fall_first", lane(got[0], 1), 200);
        chk("fall_before", lane(got[PRE-1], 1), 250);
        chk("fall_trig", lane(got[PRE], 1), 150);
        chk("fall_forced", forced, 0);

        for (int r = 0; r < 6; r++) begin
            do_arm($urandom_range(0, 1), $urandom_range(0, 4095), 1'($urandom), 1'($urandom),
                   $urandom_range(0, 20), $urandom_range(0, 3));
            capture(3, 70, -1, 0, ab);
            dump(2, -1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
